// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_HOLD,
      ST_SLEEP
   } if_state_e;

   localparam logic [31:0] BUBBLE_INS       = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_INTR_VEC = 32'h0001_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_next_pc.sv
// Redirect-priority mux (interrupt > mret > branch) and sequential +4 adder.
module if_next_pc
   import if_pkg::*;
#(
   parameter logic [31:0] INTR_VEC = DEFAULT_INTR_VEC
) (
   input  logic [31:0] pc_reg,
   input  logic        sleeping,
   input  logic        intr_take,
   input  logic        mret,
   input  logic        branch_taken,
   input  logic [31:0] mepc,
   input  logic [31:0] branch_target,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] pc_plus4
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      redirect    = 1'b0;
      redirect_pc = pc_reg;
      if (intr_take) begin
         redirect    = 1'b1;
         redirect_pc = word_align(INTR_VEC);
      end else if (!sleeping && mret) begin
         redirect    = 1'b1;
         redirect_pc = word_align(mepc);
      end else if (!sleeping && branch_taken) begin
         redirect    = 1'b1;
         redirect_pc = word_align(branch_target);
      end
   end

   assign pc_plus4 = pc_reg + 32'd4;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage: PC, imem handshake, redirects, squash and WFI sleep.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] INTR_VEC = DEFAULT_INTR_VEC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        wfi,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        intr_take,
   input  logic        mret,
   input  logic [31:0] mepc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] ins_out,
   output logic        if_valid,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_squash_cnt,
`endif
   output logic        fetch_stall
);

   if_state_e   state;
   logic [31:0] pc_reg;
   logic [31:0] req_addr;
   logic [31:0] hold_ins;
   logic        pend;
   logic        squash;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_plus4;
   logic        sleeping;
   logic        wfi_kill;
   logic        kill;
   logic        ack;
   logic        fresh_ack;

   assign sleeping = (state == ST_SLEEP);

   if_next_pc #(.INTR_VEC(INTR_VEC)) u_next_pc (
      .pc_reg        (pc_reg),
      .sleeping      (sleeping),
      .intr_take     (intr_take),
      .mret          (mret),
      .branch_taken  (branch_taken),
      .mepc          (mepc),
      .branch_target (branch_target),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .pc_plus4      (pc_plus4)
   );

   assign wfi_kill = wfi && !redirect && !sleeping;
   assign kill     = redirect || wfi_kill;

   // An issued request is held until answered; fresh ones wait for a quiet, unstalled cycle.
   assign imem_req    = pend || ((state == ST_REQ) && !stall && !kill);
   assign imem_addr   = pend ? req_addr : pc_reg;
   assign ack         = imem_req && imem_ready;
   assign fresh_ack   = ack && !squash;
   assign fetch_stall = !if_valid || (state == ST_IDLE) || sleeping || (squash && pend);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc_reg   <= word_align(RESET_PC);
         req_addr <= word_align(RESET_PC);
         hold_ins <= BUBBLE_INS;
         pend     <= 1'b0;
         squash   <= 1'b0;
         pc_out   <= 32'h0;
         ins_out  <= BUBBLE_INS;
         if_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pend <= imem_req && !imem_ready;
         if (imem_req) req_addr <= imem_addr;

         if (kill) begin
            ins_out  <= BUBBLE_INS;
            if_valid <= 1'b0;
            squash   <= imem_req && !imem_ready;
            if (redirect) begin
               pc_reg <= redirect_pc;
               state  <= ST_REQ;
            end else begin
               state  <= ST_SLEEP;
            end
         end else begin
            if (squash && ack) squash <= 1'b0;
            case (state)
               ST_IDLE: state <= ST_REQ;
               ST_REQ: begin
                  if (fresh_ack && !stall) begin
                     pc_out   <= pc_reg;
                     ins_out  <= imem_rdata;
                     if_valid <= 1'b1;
                     pc_reg   <= pc_plus4;
                  end else if (fresh_ack) begin
                     hold_ins <= imem_rdata;
                     state    <= ST_HOLD;
                  end else if (!stall) begin
                     ins_out  <= BUBBLE_INS;
                     if_valid <= 1'b0;
                  end
               end
               ST_HOLD: begin
                  if (!stall) begin
                     pc_out   <= pc_reg;
                     ins_out  <= hold_ins;
                     if_valid <= 1'b1;
                     pc_reg   <= pc_plus4;
                     state    <= ST_REQ;
                  end
               end
               ST_SLEEP: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   logic perf_load;
   logic perf_drop;

   assign perf_load = !kill && !stall &&
                      (((state == ST_REQ) && fresh_ack) || (state == ST_HOLD));
   assign perf_drop = kill ? (ack || (state == ST_HOLD)) : (squash && ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt  <= 32'h0;
         perf_squash_cnt <= 32'h0;
      end else begin
         if (perf_load) perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
         if (perf_drop) perf_squash_cnt <= perf_squash_cnt + 32'd1;
      end
   end
`endif

endmodule
